div_iter: RTL and testbench

//  Iterative radix-2^R restoring integer divider for the RV32 M-extension
//  (DIV/DIVU/REM/REMU). Sits beside the multiplier in the execute stage.

---
 rtl/div_iter.sv | 181 ++++++++++++++++++
 tb/tb_div_iter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2^R restoring divider for RV32 DIV/DIVU/REM/REMU.
// Handshake matches the multiplier: valid/ready on both sides plus a pipeline flush.
module div_iter #(
    parameter int WIDTH      = 32,
    parameter int RADIX_LOG2 = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             in_ready_o,
    input  logic             in_valid_i,
    input  logic             in_sign_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_quot_o,
    output logic [WIDTH-1:0] out_rem_o
);

    localparam int ITER = WIDTH / RADIX_LOG2;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic             accept_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic [WIDTH:0]   part_d;
    logic [WIDTH-1:0] dvd_d;

    function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand decode at the accept point: magnitudes and the two special cases.
    always_comb begin
        accept_s   = in_valid_i & in_ready_q;
        a_neg_s    = in_sign_i & in_a_i[WIDTH-1];
        b_neg_s    = in_sign_i & in_b_i[WIDTH-1];
        abs_a_s    = neg_if(a_neg_s, in_a_i);
        abs_b_s    = neg_if(b_neg_s, in_b_i);
        div_zero_s = (in_b_i == ZERO_W);
        ovf_s      = in_sign_i & (in_a_i == MIN_NEG) & (in_b_i == ONES_W);
    end

    // One CALC cycle: RADIX_LOG2 restoring steps; quotient bits fill the dividend LSBs.
    always_comb begin
        part_d = {1'b0, part_q};
        dvd_d  = dvd_q;
        for (int k = 0; k < RADIX_LOG2; k++) begin
            part_d = {part_d[WIDTH-1:0], dvd_d[WIDTH-1]};
            dvd_d  = {dvd_d[WIDTH-2:0], 1'b0};
            if (part_d >= {1'b0, dvs_q}) begin
                part_d   = part_d - {1'b0, dvs_q};
                dvd_d[0] = 1'b1;
            end else begin
                part_d   = part_d;
                dvd_d[0] = 1'b0;
            end
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            part_q      <= ZERO_W;
            dvd_q       <= ZERO_W;
            dvs_q       <= ZERO_W;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= ZERO_W;
            rem_q       <= ZERO_W;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && !flush_i) begin
                        in_ready_q <= 1'b0;
                        if (div_zero_s) begin
                            quot_q      <= ONES_W;
                            rem_q       <= in_a_i;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else if (ovf_s) begin
                            quot_q      <= in_a_i;
                            rem_q       <= ZERO_W;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            part_q     <= ZERO_W;
                            dvd_q      <= abs_a_s;
                            dvs_q      <= abs_b_s;
                            neg_quot_q <= a_neg_s ^ b_neg_s;
                            neg_rem_q  <= a_neg_s;
                            cnt_q      <= {CW{1'b0}};
                            state_q    <= ST_CALC;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        cnt_q      <= {CW{1'b0}};
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        part_q <= part_d[WIDTH-1:0];
                        dvd_q  <= dvd_d;
                        if (cnt_q == CNT_LAST) begin
                            // Sign fix-up folded into the final iteration.
                            quot_q      <= neg_if(neg_quot_q, dvd_d);
                            rem_q       <= neg_if(neg_rem_q, part_d[WIDTH-1:0]);
                            cnt_q       <= {CW{1'b0}};
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (flush_i || out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q       <= {CW{1'b0}};
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_quot_o  = quot_q;
    assign out_rem_o   = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_div_iter;

    localparam int W       = 32;
    localparam int LAT_NRM = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sign = 1'b0;
    logic [W-1:0]  in_a = 32'd0;
    logic [W-1:0]  in_b = 32'd0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_quot;
    logic [W-1:0]  out_rem;

    int vectors = 0;
    int miscompares = 0;

    div_iter #(.WIDTH(W), .RADIX_LOG2(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_ready_o(in_ready), .in_valid_i(in_valid), .in_sign_i(in_sign),
        .in_a_i(in_a), .in_b_i(in_b), .out_ready_i(out_ready),
        .out_valid_o(out_valid), .out_quot_o(out_quot), .out_rem_o(out_rem)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M-extension division semantics in plain arithmetic.
    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 1;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
            lat = LAT_NRM;
        end else begin
            q = a / b; r = a % b; lat = LAT_NRM;
        end
    endfunction

    // Issue one op and wait (bounded) for out_valid; entered and left #1 after an edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        in_sign = s; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        q = out_quot; r = out_rem;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_hs: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        vectors++;
        if (out_quot !== 32'd0 || out_rem !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_data: got q=%h r=%h expected 0 0", out_quot, out_rem);
        end
    endtask

    task automatic test_divu_basic();
        logic [W-1:0] q, r;
        int lat;
        issue(1'b0, 32'd100, 32'd7, q, r, lat);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL divu_latency: got %0d expected 33", lat);
        end
        vectors++;
        if (q !== 32'd14 || r !== 32'd2) begin
            miscompares++;
            $display("FAIL divu_100_7: got q=%0d r=%0d expected q=14 r=2", q, r);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_quot !== 32'd14 || out_rem !== 32'd2) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: got v=%b q=%0d r=%0d expected v=1 q=14 r=2",
                         i, out_valid, out_quot, out_rem);
            end
        end
        retire();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL retire: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FFF9};
        logic [W-1:0] tb [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [W-1:0] eq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
        logic [W-1:0] er [3] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
        logic [W-1:0] q, r;
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ta[i], tb[i], q, r, lat);
            vectors++;
            if (q !== eq[i] || r !== er[i] || lat !== LAT_NRM) begin
                miscompares++;
                $display("FAIL signed[%0d]: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                         i, q, r, lat, eq[i], er[i], LAT_NRM);
            end
            retire();
        end
    endtask

    task automatic test_special();
        logic [W-1:0] q, r;
        int lat;
        issue(1'b0, 32'h1234_5678, 32'd0, q, r, lat);
        vectors++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678 || lat !== 1) begin
            miscompares++;
            $display("FAIL div_by_zero: got q=%h r=%h lat=%0d expected q=ffffffff r=12345678 lat=1",
                     q, r, lat);
        end
        retire();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, lat);
        vectors++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || lat !== 1) begin
            miscompares++;
            $display("FAIL signed_ovf: got q=%h r=%h lat=%0d expected q=80000000 r=0 lat=1",
                     q, r, lat);
        end
        retire();
        issue(1'b1, 32'hFFFF_FFFB, 32'd0, q, r, lat);
        vectors++;
        if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || lat !== 1) begin
            miscompares++;
            $display("FAIL sdiv_by_zero: got q=%h r=%h lat=%0d expected q=ffffffff r=fffffffb lat=1",
                     q, r, lat);
        end
        retire();
    endtask

    task automatic test_flush();
        logic [W-1:0] q, r;
        int lat, pulses;
        in_sign = 1'b0; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_calc: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) pulses++; end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL flush_no_result: got %0d valid cycles expected 0", pulses);
        end
        issue(1'b0, 32'd9, 32'd3, q, r, lat);
        vectors++;
        if (q !== 32'd3 || r !== 32'd0 || lat !== 33) begin
            miscompares++;
            $display("FAIL after_flush: got q=%0d r=%0d lat=%0d expected q=3 r=0 lat=33", q, r, lat);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hold: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        in_sign = 1'b0; in_a = 32'd50; in_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid || !in_ready) pulses++; end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL flush_at_accept: got %0d busy/valid cycles expected 0", pulses);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] q, r;
        int lat;
        in_sign = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h0000_1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quot !== 32'd0 || out_rem !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset: got rdy=%b vld=%b q=%h r=%h expected 1 0 0 0",
                     in_ready, out_valid, out_quot, out_rem);
        end
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 32'd77, 32'd5, q, r, lat);
        vectors++;
        if (q !== 32'd15 || r !== 32'd2 || lat !== 33) begin
            miscompares++;
            $display("FAIL post_async_op: got q=%0d r=%0d lat=%0d expected q=15 r=2 lat=33", q, r, lat);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, q, r, eq, er;
        int lat, elat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            ref_div(1'b0, a, b, eq, er, elat);
            issue(1'b0, a, b, q, r, lat);
            vectors++;
            if (q !== eq || r !== er || lat !== elat) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                         i, q, r, lat, eq, er, elat);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_single_pulse[%0d]: got vld=%b expected 0", i, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic s;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            ref_div(s, a, b, eq, er, elat);
            issue(s, a, b, q, r, lat);
            vectors++;
            if (q !== eq || r !== er || lat !== elat) begin
                miscompares++;
                $display("FAIL random[%0d] s=%b a=%h b=%h: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                         i, s, a, b, q, r, lat, eq, er, elat);
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
